// File: rtl/riscv_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_lsu_if
//  Description : Data-memory handshake between the load/store unit and a
//                variable-latency data memory.
//                  mem_req   - request, held until acknowledged
//                  mem_we    - write strobe
//                  mem_addr  - word address (bits [1:0] are zero)
//                  mem_be    - byte-lane enables
//                  mem_wdata - lane-replicated store data
//                  mem_ack   - memory accepts/completes in this cycle
//                  mem_rdata - read data, valid with mem_ack on a load
//  Modports    : master = LSU side, slave = memory side
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_lsu
//  Description : Load/store unit. Accepts a load/store from the datapath,
//                runs a variable-latency memory handshake, stalls the core
//                while the access is in flight and returns aligned,
//                sign/zero-extended load data for writeback.
//  Ports       : clk, reset (sync, active-low)
//                req_valid/req_we/req_funct3/req_addr/req_wdata - request
//                req_ready  - LSU idle
//                stall_out  - hold PC, suppress writeback
//                rsp_valid/rsp_rdata - one-cycle completion + load data
//                err_misalign/err_timeout - error pulses with rsp_valid
//                mem        - data-memory handshake (riscv_lsu_if.master)
//  Parameters  : TIMEOUT_CYC - BUSY cycles without ack before abort (1..255)
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall_out,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    riscv_lsu_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter value seen in the last allowed BUSY cycle.
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err_mis;
    logic        r_err_to;

    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic        w_timeout;

    assign w_timeout = (r_cnt == c_cnt_last);

    // Legality: alignment per access size, and funct3 values valid for the
    // direction (unsigned variants exist only for loads).
    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = ~req_addr[0];
            3'd2:    w_legal = (req_addr[1:0] == 2'b00);
            3'd4:    w_legal = ~req_we;
            3'd5:    w_legal = ~req_we & ~req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    // Lane enables and lane-replicated store data; funct3[1:0] is the size.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0, then extend.
    assign w_shift = mem.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_funct3)
            3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd1:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd4:    w_load = {24'd0, w_shift[7:0]};
            3'd5:    w_load = {16'd0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
        if (r_we) begin
            w_load = 32'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_nxt = w_legal ? ST_BUSY : ST_RESP;
            ST_BUSY: if (mem.mem_ack || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_cnt       <= 8'd0;
            r_rdata     <= 32'd0;
            r_err_mis   <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_off       <= req_addr[1:0];
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_cnt       <= 8'd0;
                        r_rdata     <= 32'd0;
                        r_err_mis   <= ~w_legal;
                        r_err_to    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // An ack in the final allowed cycle wins over the timeout.
                    if (mem.mem_ack) begin
                        r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_err_to <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.mem_req   = (r_state == ST_BUSY);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_be    = r_mem_be;
    assign mem.mem_wdata = r_mem_wdata;

    assign rsp_valid    = (r_state == ST_RESP);
    assign rsp_rdata    = rsp_valid ? r_rdata : 32'd0;
    assign err_misalign = rsp_valid & r_err_mis;
    assign err_timeout  = rsp_valid & r_err_to;

    // Gated by reset so both read 0 while reset is held.
    assign req_ready = reset & (r_state == ST_IDLE);
    assign stall_out = reset & (((r_state == ST_IDLE) & req_valid) | (r_state == ST_BUSY));

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_lsu
//  Description : Directed self-checking bench for riscv_lsu. Instance u_dut
//                uses the default timeout, u_dut_to uses TIMEOUT_CYC=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_b, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, stall_out, rsp_valid, err_misalign, err_timeout;
    logic [31:0] rsp_rdata;
    logic        b_req_ready, b_stall_out, b_rsp_valid, b_err_misalign, b_err_timeout;
    logic [31:0] b_rsp_rdata;

    int checks_cnt = 0;
    int errors_cnt = 0;

    riscv_lsu_if mem_a();
    riscv_lsu_if mem_b();

    always #5 clk = ~clk;

    riscv_lsu u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .stall_out    (stall_out),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .mem          (mem_a)
    );

    riscv_lsu #(.TIMEOUT_CYC(4)) u_dut_to (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid_b),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (b_req_ready),
        .stall_out    (b_stall_out),
        .rsp_valid    (b_rsp_valid),
        .rsp_rdata    (b_rsp_rdata),
        .err_misalign (b_err_misalign),
        .err_timeout  (b_err_timeout),
        .mem          (mem_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on u_dut. ack_dly = BUSY cycles without ack before the ack cycle.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_dly, input logic [31:0] mrdata,
                          input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_mis);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, "/ready"}, req_ready, 1'b1);
        check({tag, "/stall_acc"}, stall_out, 1'b1);
        tick();
        if (exp_mis) begin
            check({tag, "/rsp_valid"}, rsp_valid, 1'b1);
            check({tag, "/err_mis"}, err_misalign, 1'b1);
            check({tag, "/err_to"}, err_timeout, 1'b0);
            check({tag, "/mem_req"}, mem_a.mem_req, 1'b0);
            check({tag, "/stall_resp"}, stall_out, 1'b0);
            check({tag, "/rdata"}, rsp_rdata, 32'd0);
        end else begin
            for (int i = 0; i <= ack_dly; i++) begin
                if (i == ack_dly) begin
                    mem_a.mem_ack = 1'b1;
                    mem_a.mem_rdata = mrdata;
                end
                #1;
                check({tag, "/mem_req"}, mem_a.mem_req, 1'b1);
                check({tag, "/mem_addr"}, mem_a.mem_addr, {addr[31:2], 2'b00});
                check({tag, "/mem_be"}, mem_a.mem_be, exp_be);
                check({tag, "/mem_we"}, mem_a.mem_we, we);
                if (we) check({tag, "/mem_wdata"}, mem_a.mem_wdata, exp_wdata);
                check({tag, "/stall_busy"}, stall_out, 1'b1);
                check({tag, "/no_rsp"}, rsp_valid, 1'b0);
                tick();
            end
            mem_a.mem_ack = 1'b0;
            mem_a.mem_rdata = 32'h5555_5555;
            #1;
            check({tag, "/rsp_valid"}, rsp_valid, 1'b1);
            check({tag, "/rdata"}, rsp_rdata, exp_rdata);
            check({tag, "/err_mis"}, err_misalign, 1'b0);
            check({tag, "/err_to"}, err_timeout, 1'b0);
            check({tag, "/mem_req_off"}, mem_a.mem_req, 1'b0);
            check({tag, "/stall_resp"}, stall_out, 1'b0);
        end
        // req_valid is still high in RESP and must not start a new access.
        tick();
        req_valid = 1'b0;
        #1;
        check({tag, "/idle_ready"}, req_ready, 1'b1);
        check({tag, "/idle_rsp"}, rsp_valid, 1'b0);
        check({tag, "/idle_req"}, mem_a.mem_req, 1'b0);
    endtask

    // LW on u_dut_to. ack_at = BUSY cycle (1..4) carrying the ack, 0 = never.
    task automatic access_b(input string tag, input int ack_at);
        req_valid_b = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400; req_wdata = 32'd0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (i == ack_at) begin
                mem_b.mem_ack = 1'b1;
                mem_b.mem_rdata = 32'h1234_5678;
            end
            #1;
            check({tag, "/mem_req"}, mem_b.mem_req, 1'b1);
            check({tag, "/no_rsp"}, b_rsp_valid, 1'b0);
            tick();
            if (i == ack_at) break;
        end
        mem_b.mem_ack = 1'b0;
        #1;
        check({tag, "/rsp_valid"}, b_rsp_valid, 1'b1);
        check({tag, "/err_to"}, b_err_timeout, (ack_at == 0));
        check({tag, "/rdata"}, b_rsp_rdata, (ack_at == 0) ? 32'd0 : 32'h1234_5678);
        check({tag, "/mem_req_off"}, mem_b.mem_req, 1'b0);
        tick();
        req_valid_b = 1'b0;
        #1;
        check({tag, "/idle_ready"}, b_req_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/req_ready"}, req_ready, 1'b0);
        check({tag, "/stall"}, stall_out, 1'b0);
        check({tag, "/rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "/rdata"}, rsp_rdata, 32'd0);
        check({tag, "/err_mis"}, err_misalign, 1'b0);
        check({tag, "/err_to"}, err_timeout, 1'b0);
        check({tag, "/mem_req"}, mem_a.mem_req, 1'b0);
        check({tag, "/mem_we"}, mem_a.mem_we, 1'b0);
        check({tag, "/mem_addr"}, mem_a.mem_addr, 32'd0);
        check({tag, "/mem_be"}, mem_a.mem_be, 4'd0);
        check({tag, "/mem_wdata"}, mem_a.mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_a.mem_ack = 1'b0; mem_a.mem_rdata = 32'd0;
        mem_b.mem_ack = 1'b0; mem_b.mem_rdata = 32'd0;
        tick();
        tick();
        check_all_zero("reset");
        check("reset/b_ready", b_req_ready, 1'b0);
        reset = 1'b1;
        tick();
        check("post_reset/ready", req_ready, 1'b1);

        //     tag     we   f3    addr      wdata          dly mem_rdata      exp_rdata      be     exp_wdata      mis
        access("lw",   0, 3'd2, 32'h100, 32'd0,          0, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 32'd0,         0);
        access("lb",   0, 3'd0, 32'h103, 32'd0,          0, 32'h80FF0011, 32'hFFFFFF80, 4'h8, 32'd0,         0);
        access("lbu",  0, 3'd4, 32'h103, 32'd0,          1, 32'h80FF0011, 32'h00000080, 4'h8, 32'd0,         0);
        access("lb2",  0, 3'd0, 32'h102, 32'd0,          0, 32'h80FF0011, 32'hFFFFFFFF, 4'h4, 32'd0,         0);
        access("lh",   0, 3'd1, 32'h102, 32'd0,          2, 32'h80FF0011, 32'hFFFF80FF, 4'hC, 32'd0,         0);
        access("lhu",  0, 3'd5, 32'h102, 32'd0,          0, 32'h80FF0011, 32'h000080FF, 4'hC, 32'd0,         0);
        access("lh0",  0, 3'd1, 32'h100, 32'd0,          0, 32'h80FF0011, 32'h00000011, 4'h3, 32'd0,         0);
        access("sb",   1, 3'd0, 32'h201, 32'h0000002A,   4, 32'hFFFFFFFF, 32'd0,        4'h2, 32'h2A2A2A2A,  0);
        access("sh",   1, 3'd1, 32'h202, 32'h1234ABCD,   1, 32'hFFFFFFFF, 32'd0,        4'hC, 32'hABCDABCD,  0);
        access("sw",   1, 3'd2, 32'h204, 32'hCAFEF00D,   0, 32'hFFFFFFFF, 32'd0,        4'hF, 32'hCAFEF00D,  0);
        access("sw_mis", 1, 3'd2, 32'h302, 32'h1,        0, 32'd0,        32'd0,        4'hF, 32'd0,         1);
        access("lh_mis", 0, 3'd1, 32'h301, 32'd0,        0, 32'd0,        32'd0,        4'hF, 32'd0,         1);
        access("lw_mis", 0, 3'd2, 32'h101, 32'd0,        0, 32'd0,        32'd0,        4'hF, 32'd0,         1);
        access("f3_3",   0, 3'd3, 32'h300, 32'd0,        0, 32'd0,        32'd0,        4'hF, 32'd0,         1);
        access("st_f34", 1, 3'd4, 32'h300, 32'd0,        0, 32'd0,        32'd0,        4'hF, 32'd0,         1);

        access_b("timeout", 0);
        access_b("ack_last", 4);

        // Reset pulled during BUSY, then a late ack after release.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h500; req_wdata = 32'h11223344;
        tick();
        check("rst_busy/mem_req", mem_a.mem_req, 1'b1);
        reset = 1'b0;
        tick();
        check_all_zero("rst_busy");
        reset = 1'b1;
        req_valid = 1'b0;
        mem_a.mem_ack = 1'b1;
        mem_a.mem_rdata = 32'hDEAD0000;
        tick();
        mem_a.mem_ack = 1'b0;
        check("late_ack/rsp", rsp_valid, 1'b0);
        check("late_ack/ready", req_ready, 1'b1);
        check("late_ack/mem_req", mem_a.mem_req, 1'b0);
        tick();
        check("late_ack/rsp2", rsp_valid, 1'b0);
        access("lw_after", 0, 3'd2, 32'h600, 32'd0, 0, 32'h0BADF00D, 32'h0BADF00D, 4'hF, 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit sitting directly downstream of `riscv_datapath`. It takes the ALU-computed address, the rs2 store data and the funct3 of a load or store. It drives a variable-latency data-memory handshake and returns the aligned, sign/zero-extended load data for writeback. While an access is in flight it stalls the core, which lets the non-pipelined CPU work with memories slower than one cycle.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: number of BUSY cycles without `mem_ack` before the access is aborted. Range 1–255.

Ports:
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in 1: the current instruction is a load/store.
- `req_we` in 1: 1 = store, 0 = load (MemRW).
- `req_funct3` in 3: RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (rs2).
- `req_ready` out 1: LSU is in IDLE.
- `stall_out` out 1: hold PC and suppress register writeback.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data, valid with `rsp_valid`.
- `err_misalign` out 1: pulse with `rsp_valid`; misaligned address or illegal funct3.
- `err_timeout` out 1: pulse with `rsp_valid`; no ack was received.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: write strobe.
- `mem_addr` out 32: word address, with bits [1:0] = 0.
- `mem_be` out 4: byte-lane enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory accepts/completes the request in this cycle.
- `mem_rdata` in 32: read data, valid when `mem_ack`=1 on a load.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- **Acceptance**
  - IDLE with `req_valid`=1: latch we, funct3, addr and wdata.
  - Legal access: go to BUSY.
  - Illegal access: go to RESP with `err_misalign` set.
- **Legality rules**
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Legal load funct3 values: 0, 1, 2, 4, 5.
  - Legal store funct3 values: 0, 1, 2.
  - Any other combination is illegal.
- **Byte-lane enables (`mem_be`)**
  - Byte access: `1<<addr[1:0]`.
  - Halfword access: addr[1] ? 4'b1100 : 4'b0011.
  - Word access: 4'b1111.
  - `mem_be` is driven identically for loads.
- **Store data (`mem_wdata`)**
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: unchanged.
- **BUSY**
  - `mem_req`=1 and all `mem_*` outputs are stable from registers.
  - On `mem_ack`=1: capture `mem_rdata` shifted right by 8·addr[1:0], then extend it.
    - LB/LH: sign-extend.
    - LBU/LHU: zero-extend.
    - Stores: `rsp_rdata`=0.
  - Then go to RESP.
- **Timeout**
  - A cycle counter runs in BUSY.
  - When the counter reaches `TIMEOUT_CYC` with no ack: go to RESP with `err_timeout` set and `rsp_rdata`=0.
  - The counter clears on entry to BUSY.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then return to IDLE.
  - `req_valid` is ignored in RESP; it still belongs to the completing instruction.
- **`stall_out`** is combinational: (IDLE && `req_valid`) || BUSY. It is 0 in RESP, so the PC advances on the completion cycle.
- **`req_ready`** = IDLE.
- `mem_ack` is ignored outside BUSY.

## Timing
- **Reset** (`reset`=0 at an edge):
  - State returns to IDLE and the timeout counter clears.
  - Every output is 0: `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `rsp_valid`, `rsp_rdata`, both error flags, `stall_out`, `req_ready` (`req_ready` becomes 1 in the first cycle after reset is released).
  - Reset mid-BUSY drops `mem_req` at that edge; a late ack is ignored.
- **Latency**
  - Request accepted at T → `mem_req` high at T+1.
  - Ack at T+1 → `rsp_valid` at T+2.
  - Ack at T+k → `rsp_valid` at T+k+1.
  - Misaligned access: accepted at T → `rsp_valid` + `err_misalign` at T+1, with no `mem_req` ever.
  - Timeout: `mem_req` high for exactly `TIMEOUT_CYC` cycles (T+1…T+`TIMEOUT_CYC`) → `rsp_valid` + `err_timeout` at T+`TIMEOUT_CYC`+1.
- **Handshake**
  - `mem_req` stays asserted and `mem_*` stay constant until the cycle in which `mem_ack`=1.
  - `mem_req` deasserts the following cycle.
  - An ack in the same cycle `mem_req` first rises is valid.
- **Back-to-back requests**: a new access is accepted at the earliest one cycle after RESP, because the IDLE cycle is required.

## Test plan
- LW, addr 0x100, ack on first `mem_req` cycle, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_be`=4'b1111; `rsp_valid` 2 cycles after accept; `rsp_rdata`=0xDEADBEEF; `stall_out` high for exactly 2 cycles.
- LB/LBU at addr 0x103, `mem_rdata`=0x80FF0011 → `mem_be`=4'b1000; LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB 0x2A at addr 0x201, ack delayed 5 cycles → `mem_wdata`=0x2A2A2A2A, `mem_be`=4'b0010, `mem_we`=1; `mem_req` held 5 cycles with stable outputs; `rsp_valid` on the 6th cycle after accept.
- Misaligned cases:
  - SW at 0x302 → `err_misalign`+`rsp_valid` at T+1; `mem_req` never asserted.
  - LH at 0x301 → same response.
  - Load funct3=3 → same response.
- Timeout with `TIMEOUT_CYC`=4 and no ack → `mem_req` high 4 cycles; `err_timeout`+`rsp_valid` at T+5; `rsp_rdata`=0.
- Reset pulled low during BUSY, then ack asserted after release → all outputs 0; no `rsp_valid` generated; next LW completes normally.
